// File: rtl/equeuels_ord.sv
// Load/store issue queue: collapsing, CDB-snooping, stores in order, loads bypass only non-aliasing resolved stores.
// Latency: a dispatched or CDB-completed entry can issue the cycle after the capturing edge.
// Backpressure: dispatch_ready drops when full unless an issue fires the same cycle; issue holds until issuels_done.
module equeuels_ord #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OFF_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       dispatch_opcode,
    input  logic [OFF_W-1:0]           dispatch_offset,
    input  logic [TAG_W-1:0]           dispatch_rdtag,
    input  logic [TAG_W-1:0]           dispatch_rstag,
    input  logic [TAG_W-1:0]           dispatch_rttag,
    input  logic [DATA_W-1:0]          dispatch_rsdata,
    input  logic [DATA_W-1:0]          dispatch_rtdata,
    input  logic                       dispatch_rsvalid,
    input  logic                       dispatch_rtvalid,
    input  logic                       dispatch_en,
    output logic                       dispatch_ready,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    input  logic                       cdb_valid,
    output logic                       issuels_opcode,
    output logic [TAG_W-1:0]           issuels_rdtag,
    output logic [DATA_W-1:0]          issuels_addr,
    output logic [DATA_W-1:0]          issuels_data,
    output logic                       issuels_ready,
    input  logic                       issuels_done,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              opcode;
        logic [TAG_W-1:0]  rdtag;
        logic [TAG_W-1:0]  rstag;
        logic [TAG_W-1:0]  rttag;
        logic [OFF_W-1:0]  offset;
        logic [DATA_W-1:0] addr;
        logic              rsvalid;
        logic [DATA_W-1:0] rtdata;
        logic              rtvalid;
    } entry_t;

    entry_t             q     [DEPTH];
    entry_t             q_nxt [DEPTH];
    entry_t             q_up  [DEPTH];
    entry_t             disp_e;
    entry_t             shifted;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_nxt;
    logic [DEPTH-1:0]   elig;
    logic [IDX_W-1:0]   sel_idx;
    logic               found;
    logic               fire;
    logic               accept;
    int                 wr_slot;

    function automatic logic [DATA_W-1:0] eff_addr(input logic [DATA_W-1:0] base,
                                                   input logic [OFF_W-1:0]  off);
        return base + {{(DATA_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

    // An operand is captured only while still missing; resolved operands are never overwritten.
    function automatic entry_t snoop(input entry_t            e,
                                     input logic              cv,
                                     input logic [TAG_W-1:0]  ct,
                                     input logic [DATA_W-1:0] cd);
        entry_t r;
        r = e;
        if (r.valid && cv) begin
            if (!r.rsvalid && ct == r.rstag) begin
                r.rsvalid = 1'b1;
                r.addr    = eff_addr(cd, r.offset);
            end
            if (!r.rtvalid && ct == r.rttag) begin
                r.rtvalid = 1'b1;
                r.rtdata  = cd;
            end
        end
        return r;
    endfunction

    // Eligibility from registered state: stores only from the head, loads past resolved non-aliasing stores.
    always_comb begin
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid) begin
                if (q[i].opcode) begin
                    elig[i] = q[i].rsvalid;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j < i && q[j].valid && !q[j].opcode &&
                            (!q[j].rsvalid || q[j].addr[DATA_W-1:2] == q[i].addr[DATA_W-1:2])) begin
                            elig[i] = 1'b0;
                        end
                    end
                end else begin
                    elig[i] = (i == 0) && q[i].rsvalid && q[i].rtvalid;
                end
            end
        end
    end

    // Pick the oldest eligible entry; with none eligible the fields fall back to entry 0.
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign issuels_ready  = found & ~flush;
    assign issuels_opcode = q[sel_idx].opcode;
    assign issuels_rdtag  = q[sel_idx].rdtag;
    assign issuels_addr   = q[sel_idx].addr;
    assign issuels_data   = q[sel_idx].rtdata;
    assign fire           = issuels_ready & issuels_done;
    assign dispatch_ready = ~flush & ((occ < OCC_W'(DEPTH)) | fire);
    assign accept         = dispatch_en & dispatch_ready;
    assign occupancy      = occ;

    // Next queue image: collapse over the issued slot, snoop the CDB, append the dispatch, or clear on flush.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            q_up[i] = q[i + 1];
        end
        q_up[DEPTH-1] = '0;

        disp_e         = '0;
        disp_e.valid   = 1'b1;
        disp_e.opcode  = dispatch_opcode;
        disp_e.rdtag   = dispatch_rdtag;
        disp_e.rstag   = dispatch_rstag;
        disp_e.rttag   = dispatch_rttag;
        disp_e.offset  = dispatch_offset;
        disp_e.rsvalid = dispatch_rsvalid;
        disp_e.addr    = dispatch_rsvalid ? eff_addr(dispatch_rsdata, dispatch_offset) : '0;
        disp_e.rtvalid = dispatch_rtvalid;
        disp_e.rtdata  = dispatch_rtdata;

        wr_slot = int'(occ) - (fire ? 1 : 0);
        shifted = '0;
        for (int i = 0; i < DEPTH; i++) begin
            shifted = (fire && i >= int'(sel_idx)) ? q_up[i] : q[i];
            q_nxt[i] = snoop(shifted, cdb_valid, cdb_tag, cdb_data);
            if (accept && i == wr_slot) begin
                q_nxt[i] = snoop(disp_e, cdb_valid, cdb_tag, cdb_data);
            end
            if (flush) begin
                q_nxt[i] = '0;
            end
        end

        if (flush) begin
            occ_nxt = '0;
        end else begin
            occ_nxt = occ + OCC_W'(accept) - OCC_W'(fire);
        end
    end

    // State registers; reset drops every entry immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
            occ <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_equeuels_ord.sv
// Directed vector bench for the ordered load/store issue queue.
// Inputs are driven on the falling edge and outputs sampled 2 time units later.
// Multi-cycle corners (full queue, flush, async reset) use hand-written sequences.
module tb_equeuels_ord;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        dispatch_opcode;
    logic [15:0] dispatch_offset;
    logic [5:0]  dispatch_rdtag;
    logic [5:0]  dispatch_rstag;
    logic [5:0]  dispatch_rttag;
    logic [31:0] dispatch_rsdata;
    logic [31:0] dispatch_rtdata;
    logic        dispatch_rsvalid;
    logic        dispatch_rtvalid;
    logic        dispatch_en;
    logic        dispatch_ready;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_valid;
    logic        issuels_opcode;
    logic [5:0]  issuels_rdtag;
    logic [31:0] issuels_addr;
    logic [31:0] issuels_data;
    logic        issuels_ready;
    logic        issuels_done;
    logic [3:0]  occupancy;

    int passed = 0;
    int total  = 0;

    equeuels_ord #(.DEPTH(8), .TAG_W(6), .DATA_W(32), .OFF_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .dispatch_opcode(dispatch_opcode), .dispatch_offset(dispatch_offset),
        .dispatch_rdtag(dispatch_rdtag), .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_en(dispatch_en), .dispatch_ready(dispatch_ready),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
        .issuels_opcode(issuels_opcode), .issuels_rdtag(issuels_rdtag),
        .issuels_addr(issuels_addr), .issuels_data(issuels_data),
        .issuels_ready(issuels_ready), .issuels_done(issuels_done),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        de;
        logic        op;
        logic [15:0] off;
        logic [5:0]  rd;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [31:0] rsd;
        logic        rsv;
        logic [31:0] rtd;
        logic        rtv;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        dn;
        logic        x_rdy;
        logic        x_op;
        logic [5:0]  x_rd;
        logic [31:0] x_addr;
        logic [31:0] x_data;
        logic        x_drdy;
        logic [3:0]  x_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive(input vec_t v);
        flush            = v.fl;
        dispatch_en      = v.de;
        dispatch_opcode  = v.op;
        dispatch_offset  = v.off;
        dispatch_rdtag   = v.rd;
        dispatch_rstag   = v.rs;
        dispatch_rttag   = v.rt;
        dispatch_rsdata  = v.rsd;
        dispatch_rsvalid = v.rsv;
        dispatch_rtdata  = v.rtd;
        dispatch_rtvalid = v.rtv;
        cdb_valid        = v.cv;
        cdb_tag          = v.ct;
        cdb_data         = v.cd;
        issuels_done     = v.dn;
    endtask

    // One-cycle load dispatch used by the hand-written sequences.
    task automatic load(input logic [5:0] rd, input logic [31:0] base, input logic done);
        vec_t v;
        v     = '0;
        v.de  = 1'b1;
        v.op  = 1'b1;
        v.rd  = rd;
        v.rs  = 6'd1;
        v.rsd = base;
        v.rsv = 1'b1;
        v.dn  = done;
        drive(v);
    endtask

    task automatic idle(input logic done);
        vec_t v;
        v    = '0;
        v.dn = done;
        drive(v);
    endtask

    logic [5:0] drain_exp [8];

    initial begin
        reset_n = 1'b0;
        idle(1'b0);

        // Reset state, then single load with negative offset.
        tbl.push_back('{default:'0, x_drdy:1'b1});
        tbl.push_back('{default:'0, de:1'b1, op:1'b1, rd:6'd7, rs:6'd1, rsd:32'h1000, off:16'hFFFC, rsv:1'b1, dn:1'b1, x_drdy:1'b1});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_op:1'b1, x_rd:6'd7, x_addr:32'h0FFC, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, x_drdy:1'b1});
        // Store with unresolved base blocks a younger load until its address resolves to a different word.
        tbl.push_back('{default:'0, de:1'b1, rd:6'd10, rs:6'd5, rt:6'd6, x_drdy:1'b1});
        tbl.push_back('{default:'0, de:1'b1, op:1'b1, rd:6'd11, rs:6'd2, rsd:32'h2000, rsv:1'b1, x_rd:6'd10, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, cv:1'b1, ct:6'd5, cd:32'h3000, x_rd:6'd10, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, x_rdy:1'b1, x_op:1'b1, x_rd:6'd11, x_addr:32'h2000, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_op:1'b1, x_rd:6'd11, x_addr:32'h2000, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, cv:1'b1, ct:6'd6, cd:32'hDEADBEEF, dn:1'b1, x_rd:6'd10, x_addr:32'h3000, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_rd:6'd10, x_addr:32'h3000, x_data:32'hDEADBEEF, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, x_drdy:1'b1});
        // Store resolves into the load's word (0x2000 vs 0x2002): load waits for the store.
        tbl.push_back('{default:'0, de:1'b1, rd:6'd12, rs:6'd5, rt:6'd6, x_drdy:1'b1});
        tbl.push_back('{default:'0, de:1'b1, op:1'b1, rd:6'd13, rs:6'd2, rsd:32'h2000, off:16'h0002, rsv:1'b1, x_rd:6'd12, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, cv:1'b1, ct:6'd5, cd:32'h2000, x_rd:6'd12, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, dn:1'b1, x_rd:6'd12, x_addr:32'h2000, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, cv:1'b1, ct:6'd6, cd:32'h55, dn:1'b1, x_rd:6'd12, x_addr:32'h2000, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_rd:6'd12, x_addr:32'h2000, x_data:32'h55, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_op:1'b1, x_rd:6'd13, x_addr:32'h2002, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, x_drdy:1'b1});
        // CDB hits entry 2's store data and the dispatched load's base in the same cycle.
        tbl.push_back('{default:'0, de:1'b1, op:1'b1, rd:6'd1, rs:6'd21, x_drdy:1'b1});
        tbl.push_back('{default:'0, de:1'b1, op:1'b1, rd:6'd2, rs:6'd22, x_op:1'b1, x_rd:6'd1, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, de:1'b1, rd:6'd3, rs:6'd23, rsd:32'h100, off:16'h0004, rsv:1'b1, rt:6'd9, x_op:1'b1, x_rd:6'd1, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, de:1'b1, op:1'b1, rd:6'd4, rs:6'd9, off:16'h0010, cv:1'b1, ct:6'd9, cd:32'h4440, x_op:1'b1, x_rd:6'd1, x_drdy:1'b1, x_occ:4'd3});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_op:1'b1, x_rd:6'd4, x_addr:32'h4450, x_drdy:1'b1, x_occ:4'd4});
        tbl.push_back('{default:'0, cv:1'b1, ct:6'd21, cd:32'h500, dn:1'b1, x_op:1'b1, x_rd:6'd1, x_drdy:1'b1, x_occ:4'd3});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_op:1'b1, x_rd:6'd1, x_addr:32'h500, x_drdy:1'b1, x_occ:4'd3});
        tbl.push_back('{default:'0, cv:1'b1, ct:6'd22, cd:32'h104, dn:1'b1, x_op:1'b1, x_rd:6'd2, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_op:1'b1, x_rd:6'd2, x_addr:32'h104, x_drdy:1'b1, x_occ:4'd2});
        tbl.push_back('{default:'0, dn:1'b1, x_rdy:1'b1, x_rd:6'd3, x_addr:32'h104, x_data:32'h4440, x_drdy:1'b1, x_occ:4'd1});
        tbl.push_back('{default:'0, x_drdy:1'b1});

        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            chk($sformatf("v%0d_ready", i), 32'(issuels_ready),  32'(tbl[i].x_rdy));
            chk($sformatf("v%0d_opcode", i), 32'(issuels_opcode), 32'(tbl[i].x_op));
            chk($sformatf("v%0d_rdtag", i), 32'(issuels_rdtag),  32'(tbl[i].x_rd));
            chk($sformatf("v%0d_addr", i),  issuels_addr,        tbl[i].x_addr);
            chk($sformatf("v%0d_data", i),  issuels_data,        tbl[i].x_data);
            chk($sformatf("v%0d_dready", i), 32'(dispatch_ready), 32'(tbl[i].x_drdy));
            chk($sformatf("v%0d_occ", i),   32'(occupancy),      32'(tbl[i].x_occ));
        end

        // Fill with eight loads while the issue unit stalls.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load(6'(40 + k), 32'(k * 16'h100), 1'b0);
            #2;
            chk($sformatf("fill%0d_dready", k), 32'(dispatch_ready), 32'd1);
        end
        @(negedge clk);
        idle(1'b0);
        #2;
        chk("full_dready", 32'(dispatch_ready), 32'd0);
        chk("full_occ",    32'(occupancy),      32'd8);
        chk("full_rdtag",  32'(issuels_rdtag),  32'd40);
        // Full queue: issue and dispatch together.
        @(negedge clk);
        load(6'd50, 32'h0, 1'b1);
        #2;
        chk("fullfire_dready", 32'(dispatch_ready), 32'd1);
        chk("fullfire_ready",  32'(issuels_ready),  32'd1);
        @(negedge clk);
        idle(1'b0);
        #2;
        chk("fullfire_occ",   32'(occupancy),     32'd8);
        chk("fullfire_rdtag", 32'(issuels_rdtag), 32'd41);
        for (int k = 0; k < 7; k++) drain_exp[k] = 6'(41 + k);
        drain_exp[7] = 6'd50;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle(1'b1);
            #2;
            chk($sformatf("drain%0d_ready", k), 32'(issuels_ready), 32'd1);
            chk($sformatf("drain%0d_rdtag", k), 32'(issuels_rdtag), 32'(drain_exp[k]));
        end
        @(negedge clk);
        idle(1'b0);
        #2;
        chk("drained_occ", 32'(occupancy), 32'd0);

        // Flush with five eligible entries and a simultaneous dispatch.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            load(6'(20 + k), 32'h40, 1'b0);
        end
        @(negedge clk);
        load(6'd60, 32'h80, 1'b1);
        flush = 1'b1;
        #2;
        chk("flush_dready", 32'(dispatch_ready), 32'd0);
        chk("flush_ready",  32'(issuels_ready),  32'd0);
        chk("flush_occ",    32'(occupancy),      32'd5);
        @(negedge clk);
        idle(1'b1);
        #2;
        chk("postflush_occ",    32'(occupancy),      32'd0);
        chk("postflush_ready",  32'(issuels_ready),  32'd0);
        chk("postflush_dready", 32'(dispatch_ready), 32'd1);

        // Asynchronous reset in the middle of a cycle drops the queue at once.
        @(negedge clk);
        load(6'd33, 32'h10, 1'b0);
        @(negedge clk);
        idle(1'b0);
        #2;
        chk("prereset_occ", 32'(occupancy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("areset_occ",   32'(occupancy),     32'd0);
        chk("areset_ready", 32'(issuels_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
